// File: rtl/axi_read_router_if.sv
// rtl/axi_read_router_if.sv - AXI read channel bundle (AR + R) with master/slave views
interface axi_read_router_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_router.sv
// rtl/axi_read_router.sv - 2-master x 3-slave AXI read crossbar, one burst in flight, DECERR default slave
module axi_read_router (
    input  logic              clk,
    input  logic              rst,
    axi_read_router_if.slave  m0_if,
    axi_read_router_if.slave  m1_if,
    axi_read_router_if.master s0_if,
    axi_read_router_if.master s1_if,
    axi_read_router_if.master s2_if
);
    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] IM_BASE     = 32'h0001_0000;
    localparam logic [31:0] DM_BASE     = 32'h0002_0000;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  SEL_NONE    = 2'd3;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DEFAULT} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d, pref_q, pref_d;
    logic [3:0]  id_q, id_d, len_q, len_d, cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d, sel_q, sel_d;

    logic [1:0]       m_arvalid, m_rready, m_arready, m_rvalid, m_rlast;
    logic [1:0][3:0]  m_arid, m_arlen, m_rid;
    logic [1:0][31:0] m_araddr, m_rdata;
    logic [1:0][2:0]  m_arsize;
    logic [1:0][1:0]  m_arburst, m_rresp;

    // Slave arrays carry a fourth all-zero entry so SEL_NONE indexes safely.
    logic [3:0]       s_arready, s_rvalid, s_rlast, s_arvalid, s_rready;
    logic [3:0][7:0]  s_rid;
    logic [3:0][31:0] s_rdata;
    logic [3:0][1:0]  s_rresp;

    logic       pick, req_any;
    logic [7:0] ar_id_out;

    assign m_arvalid = {m1_if.arvalid, m0_if.arvalid};
    assign m_rready  = {m1_if.rready,  m0_if.rready};
    assign m_arid    = {m1_if.arid,    m0_if.arid};
    assign m_arlen   = {m1_if.arlen,   m0_if.arlen};
    assign m_araddr  = {m1_if.araddr,  m0_if.araddr};
    assign m_arsize  = {m1_if.arsize,  m0_if.arsize};
    assign m_arburst = {m1_if.arburst, m0_if.arburst};

    assign s_arready = {1'b0,  s2_if.arready, s1_if.arready, s0_if.arready};
    assign s_rvalid  = {1'b0,  s2_if.rvalid,  s1_if.rvalid,  s0_if.rvalid};
    assign s_rlast   = {1'b0,  s2_if.rlast,   s1_if.rlast,   s0_if.rlast};
    assign s_rid     = {8'h0,  s2_if.rid,     s1_if.rid,     s0_if.rid};
    assign s_rdata   = {32'h0, s2_if.rdata,   s1_if.rdata,   s0_if.rdata};
    assign s_rresp   = {2'b0,  s2_if.rresp,   s1_if.rresp,   s0_if.rresp};

    function automatic logic [1:0] decode(input logic [31:0] a);
        if (a[31:14] == ROM_BASE[31:14])     return 2'd0;
        else if (a[31:16] == IM_BASE[31:16]) return 2'd1;
        else if (a[31:16] == DM_BASE[31:16]) return 2'd2;
        else                                 return SEL_NONE;
    endfunction

    // pref_q names the tie winner; it flips away from whoever was just granted.
    assign req_any = |m_arvalid;
    assign pick    = (&m_arvalid) ? pref_q : m_arvalid[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            pref_q  <= 1'b0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pref_q  <= pref_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pref_d  = pref_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        burst_d = burst_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    pref_d  = ~pick;
                    id_d    = m_arid[pick];
                    len_d   = m_arlen[pick];
                    addr_d  = m_araddr[pick];
                    size_d  = m_arsize[pick];
                    burst_d = m_arburst[pick];
                    sel_d   = decode(m_araddr[pick]);
                    cnt_d   = '0;
                    state_d = (sel_d == SEL_NONE) ? DEFAULT : ADDR;
                end
            end
            ADDR: if (s_arready[sel_q]) state_d = DATA;
            DATA: if (s_rvalid[sel_q] && m_rready[grant_q] && s_rlast[sel_q]) state_d = IDLE;
            DEFAULT: begin
                if (m_rready[grant_q]) begin
                    if (cnt_q == len_q) state_d = IDLE;
                    else                cnt_d   = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_arvalid = '0;
        s_rready  = '0;
        case (state_q)
            IDLE:    m_arready[pick] = req_any;
            ADDR:    s_arvalid[sel_q] = 1'b1;
            DATA: begin
                m_rvalid[grant_q] = s_rvalid[sel_q];
                m_rlast[grant_q]  = s_rlast[sel_q];
                m_rdata[grant_q]  = s_rdata[sel_q];
                m_rresp[grant_q]  = s_rresp[sel_q];
                m_rid[grant_q]    = s_rid[sel_q][3:0];
                s_rready[sel_q]   = m_rready[grant_q];
            end
            DEFAULT: begin
                m_rvalid[grant_q] = 1'b1;
                m_rlast[grant_q]  = (cnt_q == len_q);
                m_rresp[grant_q]  = RESP_DECERR;
                m_rid[grant_q]    = id_q;
            end
            default: ;
        endcase
    end

    assign ar_id_out = {3'b000, grant_q, id_q};

    assign m0_if.arready = m_arready[0];
    assign m0_if.rvalid  = m_rvalid[0];
    assign m0_if.rlast   = m_rlast[0];
    assign m0_if.rid     = m_rid[0];
    assign m0_if.rdata   = m_rdata[0];
    assign m0_if.rresp   = m_rresp[0];
    assign m1_if.arready = m_arready[1];
    assign m1_if.rvalid  = m_rvalid[1];
    assign m1_if.rlast   = m_rlast[1];
    assign m1_if.rid     = m_rid[1];
    assign m1_if.rdata   = m_rdata[1];
    assign m1_if.rresp   = m_rresp[1];

    // AR payload reaches only the slave currently being addressed.
    assign s0_if.arvalid = s_arvalid[0];
    assign s0_if.rready  = s_rready[0];
    assign s0_if.arid    = s_arvalid[0] ? ar_id_out : '0;
    assign s0_if.araddr  = s_arvalid[0] ? addr_q    : '0;
    assign s0_if.arlen   = s_arvalid[0] ? len_q     : '0;
    assign s0_if.arsize  = s_arvalid[0] ? size_q    : '0;
    assign s0_if.arburst = s_arvalid[0] ? burst_q   : '0;
    assign s1_if.arvalid = s_arvalid[1];
    assign s1_if.rready  = s_rready[1];
    assign s1_if.arid    = s_arvalid[1] ? ar_id_out : '0;
    assign s1_if.araddr  = s_arvalid[1] ? addr_q    : '0;
    assign s1_if.arlen   = s_arvalid[1] ? len_q     : '0;
    assign s1_if.arsize  = s_arvalid[1] ? size_q    : '0;
    assign s1_if.arburst = s_arvalid[1] ? burst_q   : '0;
    assign s2_if.arvalid = s_arvalid[2];
    assign s2_if.rready  = s_rready[2];
    assign s2_if.arid    = s_arvalid[2] ? ar_id_out : '0;
    assign s2_if.araddr  = s_arvalid[2] ? addr_q    : '0;
    assign s2_if.arlen   = s_arvalid[2] ? len_q     : '0;
    assign s2_if.arsize  = s_arvalid[2] ? size_q    : '0;
    assign s2_if.arburst = s_arvalid[2] ? burst_q   : '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_arvalid[3], s_rready[3], s_rid[0][7:4], s_rid[1][7:4],
                         s_rid[2][7:4], s_rid[3][7:4]};
endmodule

// File: tb/tb_axi_read_router.sv
// tb/tb_axi_read_router.sv - self-checking bench for axi_read_router
module tb_axi_read_router;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_read_router_if #(.ID_W(4)) m0 ();
    axi_read_router_if #(.ID_W(4)) m1 ();
    axi_read_router_if #(.ID_W(8)) s0 ();
    axi_read_router_if #(.ID_W(8)) s1 ();
    axi_read_router_if #(.ID_W(8)) s2 ();

    axi_read_router dut (
        .clk   (clk),
        .rst   (rst),
        .m0_if (m0),
        .m1_if (m1),
        .s0_if (s0),
        .s1_if (s1),
        .s2_if (s2)
    );

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          stall;
        int          slave;
        logic [7:0]  arid_s;
        logic [31:0] base;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_arready(input int m);
        return (m == 1) ? m1.arready : m0.arready;
    endfunction

    function automatic logic get_rvalid(input int m);
        return (m == 1) ? m1.rvalid : m0.rvalid;
    endfunction

    function automatic logic [38:0] get_rbeat(input int m);
        if (m == 1) return {m1.rdata, m1.rresp, m1.rlast, m1.rid};
        return {m0.rdata, m0.rresp, m0.rlast, m0.rid};
    endfunction

    function automatic logic [2:0] get_s_arvalid();
        return {s2.arvalid, s1.arvalid, s0.arvalid};
    endfunction

    function automatic logic [48:0] get_s_ar(input int s);
        case (s)
            0:       return {s0.arid, s0.araddr, s0.arlen, s0.arsize, s0.arburst};
            1:       return {s1.arid, s1.araddr, s1.arlen, s1.arsize, s1.arburst};
            default: return {s2.arid, s2.araddr, s2.arlen, s2.arsize, s2.arburst};
        endcase
    endfunction

    function automatic logic get_s_rready(input int s);
        case (s)
            0:       return s0.rready;
            1:       return s1.rready;
            default: return s2.rready;
        endcase
    endfunction

    function automatic logic all_out_or();
        return |{m0.arready, m0.rid, m0.rdata, m0.rresp, m0.rlast, m0.rvalid,
                 m1.arready, m1.rid, m1.rdata, m1.rresp, m1.rlast, m1.rvalid,
                 s0.arid, s0.araddr, s0.arlen, s0.arsize, s0.arburst, s0.arvalid, s0.rready,
                 s1.arid, s1.araddr, s1.arlen, s1.arsize, s1.arburst, s1.arvalid, s1.rready,
                 s2.arid, s2.araddr, s2.arlen, s2.arsize, s2.arburst, s2.arvalid, s2.rready};
    endfunction

    task automatic set_m_ar(input int m, input logic v, input logic [3:0] id,
                            input logic [31:0] a, input logic [3:0] len);
        if (m == 1) begin
            m1.arvalid = v; m1.arid = id; m1.araddr = a; m1.arlen = len;
            m1.arsize = 3'd2; m1.arburst = 2'b01;
        end else begin
            m0.arvalid = v; m0.arid = id; m0.araddr = a; m0.arlen = len;
            m0.arsize = 3'd2; m0.arburst = 2'b01;
        end
    endtask

    task automatic set_m_rready(input int m, input logic r);
        if (m == 1) m1.rready = r;
        else        m0.rready = r;
    endtask

    task automatic set_s_r(input int s, input logic v, input logic [7:0] rid,
                           input logic [31:0] d, input logic last);
        case (s)
            0: begin s0.rvalid = v; s0.rid = rid; s0.rdata = d; s0.rlast = last; s0.rresp = 2'b00; end
            1: begin s1.rvalid = v; s1.rid = rid; s1.rdata = d; s1.rlast = last; s1.rresp = 2'b00; end
            default: begin s2.rvalid = v; s2.rid = rid; s2.rdata = d; s2.rlast = last; s2.rresp = 2'b00; end
        endcase
    endtask

    // Returns at the negedge after the AR handshake edge (cycle N+1), payload scrambled.
    task automatic ar_phase(input int m, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        int n;
        @(negedge clk);
        set_m_ar(m, 1'b1, id, a, len);
        #1;
        n = 0;
        while (!get_arready(m) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ar_handshake", 64'(get_arready(m)), 64'd1);
        @(negedge clk);
        set_m_ar(m, 1'b0, 4'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic finish_phase(input vec_t v);
        beat_t e;
        for (int b = 0; b <= int'(v.len); b++) begin
            e.data = (v.slave == 3) ? 32'h0 : v.base + 32'(b);
            e.resp = (v.slave == 3) ? 2'b11 : 2'b00;
            e.last = (b == int'(v.len));
            e.id   = v.id;
            sb.push_back(e);
        end
        #1;
        if (v.slave != 3) begin
            chk("s_arvalid", 64'(get_s_arvalid()), 64'(3'b001 << v.slave));
            chk("s_ar_payload", 64'(get_s_ar(v.slave)), 64'({v.arid_s, v.addr, v.len, 3'd2, 2'b01}));
            @(negedge clk);
        end else begin
            chk("no_s_arvalid", 64'(get_s_arvalid()), 64'd0);
        end
        for (int b = 0; b <= int'(v.len); b++) begin
            if (v.slave != 3)
                set_s_r(v.slave, 1'b1, {3'b000, 1'(v.m), v.id}, v.base + 32'(b), b == int'(v.len));
            if (b == 0) begin
                for (int k = 0; k < v.stall; k++) begin
                    set_m_rready(v.m, 1'b0);
                    #1;
                    e = sb[0];
                    chk("stall_hold", 64'({get_rvalid(v.m), get_rbeat(v.m)}),
                        64'({1'b1, e.data, e.resp, e.last, e.id}));
                    @(negedge clk);
                end
            end
            set_m_rready(v.m, 1'b1);
            #1;
            chk("other_rvalid", 64'(get_rvalid(1 - v.m)), 64'd0);
            if (v.slave != 3) chk("s_rready", 64'(get_s_rready(v.slave)), 64'd1);
            if (get_rvalid(v.m) && sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat", 64'(get_rbeat(v.m)), 64'({e.data, e.resp, e.last, e.id}));
            end else begin
                chk("rvalid", 64'(get_rvalid(v.m)), 64'd1);
            end
            @(negedge clk);
        end
        set_m_rready(v.m, 1'b0);
        if (v.slave != 3) set_s_r(v.slave, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        ar_phase(v.m, v.id, v.addr, v.len);
        finish_phase(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv;
        vecs[0] = '{0, 4'h3, 32'h0000_0010, 4'd0, 0, 0, 8'h03, 32'hDEAD_BEEF};
        vecs[1] = '{1, 4'h5, 32'h0002_0040, 4'd1, 0, 2, 8'h15, 32'h2200_0000};
        vecs[2] = '{1, 4'hA, 32'h1000_0000, 4'd3, 0, 3, 8'h00, 32'h0};
        vecs[3] = '{0, 4'h7, 32'h0001_0100, 4'd2, 0, 1, 8'h07, 32'h1100_0000};
        vecs[4] = '{0, 4'h1, 32'h0000_3FFC, 4'd0, 5, 0, 8'h01, 32'h3300_0000};
        vecs[5] = '{0, 4'h2, 32'h0000_4000, 4'd0, 0, 3, 8'h00, 32'h0};
        vecs[6] = '{1, 4'hF, 32'h0001_FFFC, 4'd1, 0, 1, 8'h1F, 32'h4400_0000};
        vecs[7] = '{0, 4'h0, 32'h0003_0000, 4'd1, 0, 3, 8'h00, 32'h0};
        vecs[8] = '{1, 4'h9, 32'h0002_FFF0, 4'd0, 2, 2, 8'h19, 32'h5500_0000};

        rst = 1'b1;
        set_m_ar(0, 1'b0, 4'h0, 32'h0, 4'h0);
        set_m_ar(1, 1'b0, 4'h0, 32'h0, 4'h0);
        set_m_rready(0, 1'b0);
        set_m_rready(1, 1'b0);
        for (int s = 0; s < 3; s++) set_s_r(s, 1'b0, 8'h0, 32'h0, 1'b0);
        s0.arready = 1'b1;
        s1.arready = 1'b1;
        s2.arready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 64'(all_out_or()), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a ROM burst
        ar_phase(0, 4'h2, 32'h0000_0100, 4'd3);
        @(negedge clk);
        set_s_r(0, 1'b1, 8'h02, 32'hCAFE_0000, 1'b0);
        #1;
        chk("pre_rst_rvalid", 64'(m0.rvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'(all_out_or()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_s_r(0, 1'b0, 8'h0, 32'h0, 1'b0);
        #1;
        chk("post_rst_idle", 64'(all_out_or()), 64'd0);

        // Back-to-back ties right after reset: M0, M1, M0
        for (int r = 0; r < 3; r++) begin
            int w;
            w = r % 2;
            @(negedge clk);
            set_m_ar(0, 1'b1, 4'h4, 32'h0000_0020, 4'd0);
            set_m_ar(1, 1'b1, 4'h6, 32'h0001_0020, 4'd0);
            #1;
            chk("tie_arready", 64'({m1.arready, m0.arready}), (w == 1) ? 64'd2 : 64'd1);
            @(negedge clk);
            set_m_ar(0, 1'b0, 4'h0, 32'h0, 4'h0);
            set_m_ar(1, 1'b0, 4'h0, 32'h0, 4'h0);
            if (w == 1) tv = '{1, 4'h6, 32'h0001_0020, 4'd0, 0, 1, 8'h16, 32'h1600_0000};
            else        tv = '{0, 4'h4, 32'h0000_0020, 4'd0, 0, 0, 8'h04, 32'h0400_0000};
            finish_phase(tv);
        end

        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
